// File: rtl/datapath_pipe.sv
// datapath_pipe: two-stage datapath (issue / execute+writeback).
//   Stage 1 reads the register file (with forwarding from the op in
//   execute), selects the B operand or immediate, and latches the
//   micro-op into the execute registers.
//   Stage 2 runs the ALU or waits for load data, writes back to the
//   register file and updates the Z/N/C/V flags.
//
// Ports:
//   clk_main      clock, all state changes on the rising edge
//   reset         synchronous active-high reset
//   issue_valid   control unit presents a micro-op
//   issue_ready   datapath accepts the micro-op this cycle
//   DR/SA/SB      destination / source A / source B register addresses
//   FS            ALU function select
//   MB            1: B operand is the zero-extended immediate {SA,SB}
//   MD            1: write back DataIn (load), 0: ALU result
//   RW            register write enable
//   DataIn        memory read data, qualified by DataIn_valid
//   BusA          A operand of the op in execute
//   DataOut       B operand of the op in execute
//   AddrOut       low AW bits of BusA
//   wb_valid      op in execute completes this cycle
//   Z/N/C/V       registered flags
module datapath_pipe #(
    parameter int WIDTH = 16,
    parameter int NREG  = 16,
    parameter int RA_W  = 4,
    parameter int AW    = 6
) (
    input  logic             clk_main,
    input  logic             reset,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [RA_W-1:0]  DR,
    input  logic [RA_W-1:0]  SA,
    input  logic [RA_W-1:0]  SB,
    input  logic [3:0]       FS,
    input  logic             MB,
    input  logic             MD,
    input  logic             RW,
    input  logic [WIDTH-1:0] DataIn,
    input  logic             DataIn_valid,
    output logic [WIDTH-1:0] BusA,
    output logic [WIDTH-1:0] DataOut,
    output logic [AW-1:0]    AddrOut,
    output logic             wb_valid,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [WIDTH-1:0] rf_q [NREG];

    logic             e_valid_q;
    logic [WIDTH-1:0] e_a_q, e_b_q;
    logic [3:0]       e_fs_q;
    logic [RA_W-1:0]  e_dr_q;
    logic             e_md_q, e_rw_q;

    logic z_q, n_q, c_q, v_q;

    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;
    logic [WIDTH:0]   sum;

    logic [WIDTH-1:0] wb_data;
    logic             rf_we;
    logic [WIDTH-1:0] a_rf, b_rf, a_d, b_d, imm;

    // ------------------------------------------------------------------
    // Handshake / writeback control
    // ------------------------------------------------------------------
    assign wb_valid    = e_valid_q && (!e_md_q || DataIn_valid);
    assign issue_ready = !(e_valid_q && e_md_q && !DataIn_valid);
    assign wb_data     = e_md_q ? DataIn : alu_res;
    assign rf_we       = wb_valid && e_rw_q && (e_dr_q != '0);

    // ------------------------------------------------------------------
    // Operand read with forwarding; R0 always reads zero
    // ------------------------------------------------------------------
    always_comb begin
        a_rf = (SA == '0) ? '0 : rf_q[SA];
        b_rf = (SB == '0) ? '0 : rf_q[SB];
        imm  = '0;
        imm[2*RA_W-1:0] = {SA, SB};
        a_d  = (rf_we && (e_dr_q == SA)) ? wb_data : a_rf;
        if (MB)
            b_d = imm;
        else
            b_d = (rf_we && (e_dr_q == SB)) ? wb_data : b_rf;
    end

    // ------------------------------------------------------------------
    // ALU on the execute-stage operands
    // ------------------------------------------------------------------
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        sum     = '0;
        unique case (e_fs_q)
            4'b0000: alu_res = e_a_q;
            4'b0001: begin
                sum     = {1'b0, e_a_q} + {{WIDTH{1'b0}}, 1'b1};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = !e_a_q[WIDTH-1] && alu_res[WIDTH-1];
            end
            4'b0010: begin
                sum     = {1'b0, e_a_q} + {1'b0, e_b_q};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (e_a_q[WIDTH-1] == e_b_q[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != e_a_q[WIDTH-1]);
            end
            4'b0101: begin
                sum     = {1'b0, e_a_q} + {1'b0, ~e_b_q} + {{WIDTH{1'b0}}, 1'b1};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (e_a_q[WIDTH-1] != e_b_q[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != e_a_q[WIDTH-1]);
            end
            4'b0110: begin
                // decrement as A + all-ones so C follows the adder carry-out
                sum     = {1'b0, e_a_q} + {1'b0, ALL_ONES};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = e_a_q[WIDTH-1] && !alu_res[WIDTH-1];
            end
            4'b1000: alu_res = e_a_q & e_b_q;
            4'b1001: alu_res = e_a_q | e_b_q;
            4'b1010: alu_res = e_a_q ^ e_b_q;
            4'b1011: alu_res = ~e_a_q;
            4'b1100: alu_res = e_b_q;
            4'b1101: begin
                alu_res = {1'b0, e_b_q[WIDTH-1:1]};
                alu_c   = e_b_q[0];
            end
            4'b1110: begin
                alu_res = {e_b_q[WIDTH-2:0], 1'b0};
                alu_c   = e_b_q[WIDTH-1];
            end
            default: alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk_main) begin
        if (reset) begin
            rf_q      <= '{default: '0};
            e_valid_q <= 1'b0;
            e_a_q     <= '0;
            e_b_q     <= '0;
            e_fs_q    <= '0;
            e_dr_q    <= '0;
            e_md_q    <= 1'b0;
            e_rw_q    <= 1'b0;
            z_q       <= 1'b0;
            n_q       <= 1'b0;
            c_q       <= 1'b0;
            v_q       <= 1'b0;
        end else begin
            if (rf_we)
                rf_q[e_dr_q] <= wb_data;

            if (issue_valid && issue_ready) begin
                e_valid_q <= 1'b1;
                e_a_q     <= a_d;
                e_b_q     <= b_d;
                e_fs_q    <= FS;
                e_dr_q    <= DR;
                e_md_q    <= MD;
                e_rw_q    <= RW;
            end else if (wb_valid) begin
                e_valid_q <= 1'b0;
            end

            if (wb_valid && !e_md_q) begin
                z_q <= (alu_res == '0);
                n_q <= alu_res[WIDTH-1];
                c_q <= alu_c;
                v_q <= alu_v;
            end
        end
    end

    assign BusA    = e_a_q;
    assign DataOut = e_b_q;
    assign AddrOut = e_a_q[AW-1:0];
    assign Z       = z_q;
    assign N       = n_q;
    assign C       = c_q;
    assign V       = v_q;

endmodule

// File: tb/tb_datapath_pipe.sv
module tb_datapath_pipe;

    logic        clk_main = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  DR, SA, SB, FS;
    logic        MB, MD, RW;
    logic [15:0] DataIn;
    logic        DataIn_valid;
    logic [15:0] BusA, DataOut;
    logic [5:0]  AddrOut;
    logic        wb_valid;
    logic        Z, N, C, V;

    int n_checks = 0;
    int n_fail   = 0;

    datapath_pipe #(.WIDTH(16), .NREG(16), .RA_W(4), .AW(6)) dut (
        .clk_main    (clk_main),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .DR          (DR),
        .SA          (SA),
        .SB          (SB),
        .FS          (FS),
        .MB          (MB),
        .MD          (MD),
        .RW          (RW),
        .DataIn      (DataIn),
        .DataIn_valid(DataIn_valid),
        .BusA        (BusA),
        .DataOut     (DataOut),
        .AddrOut     (AddrOut),
        .wb_valid    (wb_valid),
        .Z           (Z),
        .N           (N),
        .C           (C),
        .V           (V)
    );

    always #5 clk_main = ~clk_main;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_main);
        #1;
    endtask

    // Present one micro-op for a single edge, then drop issue_valid.
    task automatic issue(input logic [3:0] dr, input logic [3:0] sa, input logic [3:0] sb,
                         input logic [3:0] fs, input logic mb, input logic md, input logic rw);
        DR = dr; SA = sa; SB = sb; FS = fs; MB = mb; MD = md; RW = rw;
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic chk_flags(input string tag, input logic [3:0] exp_znvc);
        chk(tag, {12'h0, Z, N, V, C}, {12'h0, exp_znvc});
    endtask

    initial begin
        reset = 1'b1; issue_valid = 1'b0;
        DR = '0; SA = '0; SB = '0; FS = '0; MB = 1'b0; MD = 1'b0; RW = 1'b0;
        DataIn = '0; DataIn_valid = 1'b0;

        // reset state
        tick(); tick();
        chk("rst_busa", BusA, 16'h0);
        chk("rst_dout", DataOut, 16'h0);
        chk("rst_addr", {10'h0, AddrOut}, 16'h0);
        chk("rst_wbv", {15'h0, wb_valid}, 16'h0);
        chk("rst_rdy", {15'h0, issue_ready}, 16'h1);
        chk_flags("rst_flags", 4'b0000);
        reset = 1'b0;

        for (int r = 1; r < 16; r++) begin
            issue(4'd0, 4'(r), 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
            chk("rst_rf", BusA, 16'h0);
        end
        tick();

        // immediate + back-to-back forwarded add
        issue(4'd1, 4'd0, 4'd5, 4'b0010, 1'b1, 1'b0, 1'b1);
        chk("imm_b", DataOut, 16'h0005);
        chk("imm_wbv", {15'h0, wb_valid}, 16'h1);
        issue(4'd2, 4'd1, 4'd1, 4'b0010, 1'b0, 1'b0, 1'b1);
        chk("fwd_a", BusA, 16'h0005);
        chk("fwd_b", DataOut, 16'h0005);
        tick();
        chk_flags("add_flags", 4'b0000);
        issue(4'd0, 4'd2, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
        chk("r2", BusA, 16'h000A);

        // signed overflow on increment, load data forwarded
        DataIn = 16'h7FFF; DataIn_valid = 1'b1;
        issue(4'd3, 4'd0, 4'd0, 4'b0000, 1'b0, 1'b1, 1'b1);
        issue(4'd3, 4'd3, 4'd0, 4'b0001, 1'b0, 1'b0, 1'b1);
        DataIn_valid = 1'b0;
        chk("ldfwd_a", BusA, 16'h7FFF);
        tick();
        chk_flags("inc_ovf_flags", 4'b0110);
        issue(4'd0, 4'd3, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
        chk("r3", BusA, 16'h8000);

        // wrap to zero
        DataIn = 16'hFFFF; DataIn_valid = 1'b1;
        issue(4'd5, 4'd0, 4'd0, 4'b0000, 1'b0, 1'b1, 1'b1);
        issue(4'd5, 4'd5, 4'd0, 4'b0001, 1'b0, 1'b0, 1'b1);
        DataIn_valid = 1'b0;
        tick();
        chk_flags("wrap_flags", 4'b1001);

        // load stall: 3 cycles without data, a competing issue is ignored
        issue(4'd4, 4'd2, 4'd0, 4'b0000, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("stall_rdy", {15'h0, issue_ready}, 16'h0);
            chk("stall_wbv", {15'h0, wb_valid}, 16'h0);
            chk("stall_busa", BusA, 16'h000A);
            chk_flags("stall_flags", 4'b1001);
            DR = 4'd6; SA = 4'd1; SB = 4'd1; FS = 4'b0010; MB = 1'b0; MD = 1'b0; RW = 1'b1;
            issue_valid = 1'b1;
            if (i < 2) tick();
        end
        issue_valid = 1'b0;
        DataIn = 16'h1234; DataIn_valid = 1'b1;
        #1;
        chk("ld_wbv", {15'h0, wb_valid}, 16'h1);
        chk("ld_rdy", {15'h0, issue_ready}, 16'h1);
        tick();
        DataIn_valid = 1'b0;
        chk_flags("ld_flags", 4'b1001);
        issue(4'd0, 4'd4, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
        chk("r4", BusA, 16'h1234);
        issue(4'd0, 4'd6, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
        chk("r6_ignored", BusA, 16'h0000);

        // R0 protection, including no forwarding from a write to R0
        DataIn = 16'hAAAA; DataIn_valid = 1'b1;
        issue(4'd0, 4'd0, 4'd0, 4'b0000, 1'b0, 1'b1, 1'b1);
        issue(4'd0, 4'd0, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
        DataIn_valid = 1'b0;
        chk("r0_nofwd", BusA, 16'h0000);
        issue(4'd0, 4'd0, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
        chk("r0", BusA, 16'h0000);

        // subtract with borrow: 3 - 5
        issue(4'd6, 4'd0, 4'd3, 4'b1100, 1'b1, 1'b0, 1'b1);
        issue(4'd7, 4'd0, 4'd5, 4'b1100, 1'b1, 1'b0, 1'b1);
        issue(4'd8, 4'd6, 4'd7, 4'b0101, 1'b0, 1'b0, 1'b1);
        tick();
        chk_flags("sub_flags", 4'b0100);
        issue(4'd0, 4'd8, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
        chk("r8", BusA, 16'hFFFE);

        // reset while a load is stalled
        DataIn = 16'h5555; DataIn_valid = 1'b0;
        issue(4'd9, 4'd4, 4'd0, 4'b0000, 1'b0, 1'b1, 1'b1);
        chk("rs_stall_rdy", {15'h0, issue_ready}, 16'h0);
        chk("rs_addr", {10'h0, AddrOut}, 16'h0034);
        reset = 1'b1; DataIn_valid = 1'b1;
        tick();
        chk("rs_rdy", {15'h0, issue_ready}, 16'h1);
        chk("rs_wbv", {15'h0, wb_valid}, 16'h0);
        chk("rs_busa", BusA, 16'h0000);
        reset = 1'b0; DataIn_valid = 1'b0;
        issue(4'd0, 4'd9, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
        chk("rs_r9", BusA, 16'h0000);

        // logical shift right, shifted-out bit into C
        issue(4'd1, 4'd8, 4'd1, 4'b1100, 1'b1, 1'b0, 1'b1);
        chk("shimm", DataOut, 16'h0081);
        issue(4'd3, 4'd0, 4'd1, 4'b1101, 1'b0, 1'b0, 1'b1);
        chk("shfwd", DataOut, 16'h0081);
        tick();
        chk_flags("shr_flags", 4'b0001);
        issue(4'd0, 4'd3, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
        chk("r3_shr", BusA, 16'h0040);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/datapath_pipe.md
Name: datapath_pipe

Overview:
- Parametrised two-stage successor to the single-cycle datapath.
- Contains the register file, operand/immediate select, and an execute/writeback stage with forwarding.
- Provides registered Z/N/C/V flags and a valid/ready memory-load handshake that stalls issue.
- Sits between the control unit (issues one micro-op per accepted cycle) and data memory (BusA, DataOut, AddrOut, DataIn).

Parameters:
WIDTH, 16, datapath word width (>= 2*RA_W).
NREG, 16, number of registers; R0 reads as zero, writes to R0 ignored.
RA_W, 4, register address width, equals clog2(NREG).
AW, 6, memory address width driven on AddrOut (AW <= WIDTH).

Ports:
clk_main  in  1  clock, all state on rising edge
reset  in  1  synchronous active-high reset
issue_valid  in  1  control unit presents a micro-op
issue_ready  out  1  datapath accepts micro-op this cycle
DR  in  RA_W  destination register
SA  in  RA_W  source A register
SB  in  RA_W  source B register
FS  in  4  function select
MB  in  1  1: B operand = zero-extended {SA,SB}
MD  in  1  1: write back DataIn (load), 0: ALU result
RW  in  1  register write enable
DataIn  in  WIDTH  memory read data
DataIn_valid  in  1  memory read data valid
BusA  out  WIDTH  registered A operand of op in execute stage
DataOut  out  WIDTH  registered B operand of op in execute stage
AddrOut  out  AW  BusA[AW-1:0]
wb_valid  out  1  op in execute stage completes this cycle
Z, N, C, V  out  1 each  registered flags

Behaviour:
- Reset (synchronous, active-high, clk_main edge): all registers, the execute stage and the flags clear to 0; e_valid=0.
  - After reset: BusA=DataOut=AddrOut=0, wb_valid=0, issue_ready=1, Z=N=C=V=0.
  - Reset during a stall abandons the load; no register write occurs.
- Stage 1 (issue):
  - On issue_valid && issue_ready, latch into execute regs: A, B, FS, DR, MD, RW. Set e_valid=1.
  - Otherwise, if the execute op completes, clear e_valid to 0.
- A operand: RF[SA], forwarded.
- B operand:
  - MB=1: {0, SA, SB}.
  - MB=0: RF[SB], forwarded.
- Forwarding: when wb_valid && e_RW && e_DR!=0 && e_DR==SA (or SB), use the writeback value instead of the RF.
  - Back-to-back dependent ops therefore need no bubble.
- Stage 2 (execute/writeback):
  - wb_valid = e_valid && (!e_MD || DataIn_valid).
  - When wb_valid && e_RW && e_DR!=0, write at the end of the cycle:
    - MD=0: ALU result.
    - MD=1: DataIn.
- Latency: an op issued at edge n writes the RF at edge n+1 (ALU op) or at the first edge with DataIn_valid=1 (load).
- Stall: issue_ready = !(e_valid && e_MD && !DataIn_valid).
  - While stalled, execute regs, BusA/DataOut/AddrOut and flags hold.
  - issue_valid is ignored while stalled.
- ALU (WIDTH bits, wrap-around):
  - 0000 A
  - 0001 A+1
  - 0010 A+B
  - 0101 A+~B+1 (subtract; C=1 means no borrow)
  - 0110 A-1
  - 1000 A&B
  - 1001 A|B
  - 1010 A^B
  - 1011 ~A
  - 1100 B
  - 1101 B>>1 (logical)
  - 1110 B<<1
  - Any other code: result 0.
- Flags: update only on an ALU op with wb_valid (MD=0), independent of RW.
  - Z = (result==0).
  - N = result[WIDTH-1].
  - C, V = carry-out / signed overflow for add, inc, sub, dec.
  - C = shifted-out bit for shifts; V=0 for shifts.
  - C=V=0 for logic/move ops.
  - Loads leave flags unchanged.

Test Plan:
- Reset: hold reset 2 cycles -> BusA=0, wb_valid=0, issue_ready=1, Z=N=C=V=0; R1..R15 read 0.
- Immediate + add: issue R1=A(R0)+imm (MB=1,SA=0,SB=5,FS=0010); next cycle R2=R1+R1 -> R2=10 with no bubble (forwarding); Z=0, C=0.
- Overflow/wrap: R3=0x7FFF, R3+1 (FS=0001) -> R3=0x8000, N=1, V=1, C=0; then 0xFFFF+1 -> 0x0000, Z=1, C=1.
- Load stall: issue load MD=1 to R4, keep DataIn_valid=0 for 3 cycles -> issue_ready=0 for those 3 cycles, BusA held, flags held; then DataIn=0x1234 with valid -> wb_valid=1, R4=0x1234, issue_ready=1.
- R0 protection and sub borrow: write 0xAAAA to R0 -> R0 still reads 0; 3-5 (FS=0101) -> 0xFFFE, C=0, N=1.
- Reset mid-stall: assert reset while load stalled -> e_valid=0, destination register unchanged, issue_ready=1 next cycle.
